// File: rtl/bullcow_input_ctrl_if.sv
// rtl/bullcow_input_ctrl_if.sv - guess valid/ready handshake between input front end and game logic
interface bullcow_input_ctrl_if;
  logic        guess_valid;
  logic        guess_ready;
  logic [15:0] guess;

  modport master (
    output guess_valid,
    output guess,
    input  guess_ready
  );

  modport slave (
    input  guess_valid,
    input  guess,
    output guess_ready
  );
endinterface

// File: rtl/bullcow_input_ctrl.sv
// rtl/bullcow_input_ctrl.sv - synchronize/debounce enter, capture and validate a 4-digit guess
module bullcow_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2,
  parameter int DECIMAL_ONLY    = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enter,
  input  logic [15:0]                 SW,
  output logic                        guess_error,
  output logic                        enter_pulse,
  bullcow_input_ctrl_if.master        gbus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    OFFER = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] enter_sync;
  logic [15:0]            sw_sync [SYNC_STAGES];
  logic                   enter_s;
  logic [15:0]            sw_s;
  logic                   deb;
  logic                   deb_prev;
  logic [CNT_W-1:0]       db_cnt;
  logic [15:0]            guess_q;
  logic                   illegal;
  logic [3:0]             d3, d2, d1, d0;

  assign enter_s = enter_sync[SYNC_STAGES-1];
  assign sw_s    = sw_sync[SYNC_STAGES-1];

  // Multi-flop synchronizers for the button and every switch bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enter_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
    end else begin
      enter_sync <= {enter_sync[SYNC_STAGES-2:0], enter};
      sw_sync[0] <= SW;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
    end
  end

  // Debounce: flip only after the synchronized level has disagreed for a full window
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb    <= 1'b0;
      db_cnt <= '0;
    end else if (enter_s != deb) begin
      if (db_cnt == CNT_LAST) begin
        deb    <= ~deb;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Registered rising-edge detect of the debounced button
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb_prev    <= 1'b0;
      enter_pulse <= 1'b0;
    end else begin
      deb_prev    <= deb;
      enter_pulse <= deb & ~deb_prev;
    end
  end

  assign d3 = guess_q[15:12];
  assign d2 = guess_q[11:8];
  assign d1 = guess_q[7:4];
  assign d0 = guess_q[3:0];

  // Guess legality: all digits distinct, and decimal when so configured
  always_comb begin
    illegal = 1'b0;
    if ((d3 == d2) || (d3 == d1) || (d3 == d0) ||
        (d2 == d1) || (d2 == d0) || (d1 == d0))
      illegal = 1'b1;
    if ((DECIMAL_ONLY != 0) &&
        ((d3 > 4'd9) || (d2 > 4'd9) || (d1 > 4'd9) || (d0 > 4'd9)))
      illegal = 1'b1;
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state: capture on press, judge for one cycle, then hold the offer until taken
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enter_pulse) state_nxt = CHECK;
      CHECK:   state_nxt = illegal ? IDLE : OFFER;
      OFFER:   if (gbus.guess_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Guess capture only on an accepted press in IDLE; error pulse on a rejected check
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      guess_q     <= 16'h0000;
      guess_error <= 1'b0;
    end else begin
      if ((state == IDLE) && enter_pulse) guess_q <= sw_s;
      guess_error <= (state == CHECK) && illegal;
    end
  end

  assign gbus.guess       = guess_q;
  assign gbus.guess_valid = (state == OFFER);

endmodule

// File: tb/tb_bullcow_input_ctrl.sv
// tb/tb_bullcow_input_ctrl.sv - randomized and directed bench against a behavioural model
`timescale 1ns/1ps
module tb_bullcow_input_ctrl;
  localparam int DC = 4;
  localparam int SS = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        enter = 1'b0;
  logic [15:0] sw = 16'h0000;
  logic        ready = 1'b0;
  logic        err1, pulse1, err0, pulse0;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_on = 0;

  bullcow_input_ctrl_if bus1 ();
  bullcow_input_ctrl_if bus0 ();
  assign bus1.guess_ready = ready;
  assign bus0.guess_ready = ready;

  bullcow_input_ctrl #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS), .DECIMAL_ONLY(1)) dut1 (
    .clock(clock), .reset(reset), .enter(enter), .SW(sw),
    .guess_error(err1), .enter_pulse(pulse1), .gbus(bus1));

  bullcow_input_ctrl #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS), .DECIMAL_ONLY(0)) dut0 (
    .clock(clock), .reset(reset), .enter(enter), .SW(sw),
    .guess_error(err0), .enter_pulse(pulse0), .gbus(bus0));

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_illegal(input logic [15:0] g, input bit dec);
    bit bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (dec && (g[i*4 +: 4] > 4'd9)) bad = 1;
      for (int j = i + 1; j < 4; j++)
        if (g[i*4 +: 4] == g[j*4 +: 4]) bad = 1;
    end
    return bad;
  endfunction

  // Behavioural model: delay lines, run-length debounce, per-variant guess pipeline
  bit          e_line[$];
  logic [15:0] sw_line[$];
  bit          m_deb, m_deb_prev, m_pulse;
  int          m_run;
  int          m_phase [2];
  logic [15:0] m_guess [2];
  bit          m_err   [2];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      e_line.delete();
      sw_line.delete();
      for (int i = 0; i < SS; i++) begin
        e_line.push_back(1'b0);
        sw_line.push_back(16'h0);
      end
      m_deb = 0; m_deb_prev = 0; m_pulse = 0; m_run = 0;
      for (int d = 0; d < 2; d++) begin
        m_phase[d] = 0; m_guess[d] = 16'h0; m_err[d] = 0;
      end
    end else begin
      bit          se, p_old;
      logic [15:0] ssw;
      se    = e_line[SS-1];
      ssw   = sw_line[SS-1];
      p_old = m_pulse;
      e_line.push_front(enter);   void'(e_line.pop_back());
      sw_line.push_front(sw);     void'(sw_line.pop_back());
      m_pulse    = m_deb & ~m_deb_prev;
      m_deb_prev = m_deb;
      if (se != m_deb) begin
        m_run++;
        if (m_run == DC) begin m_deb = ~m_deb; m_run = 0; end
      end else m_run = 0;
      for (int d = 0; d < 2; d++) begin
        m_err[d] = 0;
        if (m_phase[d] == 0) begin
          if (p_old) begin m_guess[d] = ssw; m_phase[d] = 1; end
        end else if (m_phase[d] == 1) begin
          if (m_illegal(m_guess[d], d == 1)) begin m_err[d] = 1; m_phase[d] = 0; end
          else m_phase[d] = 2;
        end else if (ready) m_phase[d] = 0;
      end
    end
  end

  // Every-cycle comparison of both variants against the model
  always @(negedge clock) begin
    if (cmp_on) begin
      chk("pulse1", pulse1, m_pulse);
      chk("valid1", bus1.guess_valid, m_phase[1] == 2);
      chk("guess1", bus1.guess, m_guess[1]);
      chk("error1", err1, m_err[1]);
      chk("pulse0", pulse0, m_pulse);
      chk("valid0", bus0.guess_valid, m_phase[0] == 2);
      chk("guess0", bus0.guess, m_guess[0]);
      chk("error0", err0, m_err[0]);
    end
  end

  int          xfer1 = 0;
  logic [15:0] xg1;
  always @(posedge clock) if (reset && bus1.guess_valid && ready) begin xfer1++; xg1 = bus1.guess; end

  bit          p1_a[16], v1_a[16], e1_a[16], v0_a[16], e0_a[16];
  logic [15:0] g1_a[16], g0_a[16];

  task automatic obs(input logic [15:0] s);
    @(negedge clock);
    sw = s; enter = 1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clock); #1;
      p1_a[k] = pulse1; v1_a[k] = bus1.guess_valid; e1_a[k] = err1; g1_a[k] = bus1.guess;
      v0_a[k] = bus0.guess_valid; e0_a[k] = err0; g0_a[k] = bus0.guess;
    end
    @(negedge clock); enter = 0;
    repeat (12) @(negedge clock);
  endtask

  task automatic press(input int hi, input int lo);
    enter = 1; repeat (hi) @(negedge clock);
    enter = 0; repeat (lo) @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    bit any;
    int ecnt;
    bit reached;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_valid", bus1.guess_valid, 0);
    chk("rst_guess", bus1.guess, 16'h0000);
    chk("rst_error", err1, 0);
    chk("rst_pulse", pulse1, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    cmp_on = 1;
    repeat (4) @(negedge clock);

    // Clean press, ready high
    ready = 1;
    obs(16'h1234);
    chk("clean_p5", p1_a[5], 0);
    chk("clean_p6", p1_a[6], 1);
    chk("clean_p7", p1_a[7], 0);
    chk("clean_p15", p1_a[15], 0);
    chk("clean_v7", v1_a[7], 0);
    chk("clean_v8", v1_a[8], 1);
    chk("clean_g8", g1_a[8], 16'h1234);
    chk("clean_v9", v1_a[9], 0);

    // Bounce: 2-cycle toggles never pass the filter
    any = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (k % 2 == 0) enter = ~enter;
      any |= pulse1 | bus1.guess_valid | err1;
    end
    enter = 0;
    repeat (10) begin @(negedge clock); any |= pulse1 | bus1.guess_valid | err1; end
    chk("bounce_quiet", any, 0);

    // Duplicate digit
    obs(16'h1231);
    ecnt = 0; any = 0;
    for (int k = 0; k < 16; k++) begin ecnt += e1_a[k]; any |= v1_a[k]; end
    chk("dup_err8", e1_a[8], 1);
    chk("dup_errcnt", ecnt, 1);
    chk("dup_novalid", any, 0);
    chk("dup_err0_8", e0_a[8], 1);

    // Non-decimal digit: rejected only in the decimal variant
    obs(16'h12A4);
    chk("hex_err1", e1_a[8], 1);
    chk("hex_valid0", v0_a[8], 1);
    chk("hex_guess0", g0_a[8], 16'h12A4);
    chk("hex_err0", e0_a[8], 0);

    // Backpressure with a second press ignored
    ready = 0;
    sw = 16'h5678; press(8, 10);
    sw = 16'h9012; press(8, 10);
    chk("bp_valid", bus1.guess_valid, 1);
    chk("bp_guess", bus1.guess, 16'h5678);
    xfer1 = 0;
    ready = 1;
    repeat (12) @(negedge clock);
    chk("bp_xfers", xfer1, 1);
    chk("bp_xguess", xg1, 16'h5678);
    chk("bp_after", bus1.guess_valid, 0);
    chk("bp_keep", bus1.guess, 16'h5678);

    // Randomized presses, glitches, switch values and backpressure
    for (int it = 0; it < 50; it++) begin
      if ($urandom_range(0, 1) == 1) sw = 16'($urandom);
      else begin
        int dg[10];
        for (int i = 0; i < 10; i++) dg[i] = i;
        for (int i = 9; i > 0; i--) begin
          int j = $urandom_range(0, i);
          int t = dg[i]; dg[i] = dg[j]; dg[j] = t;
        end
        sw = {4'(dg[0]), 4'(dg[1]), 4'(dg[2]), 4'(dg[3])};
      end
      ready = 1'($urandom_range(0, 1));
      enter = 1;
      repeat ($urandom_range(1, 9)) @(negedge clock);
      if ($urandom_range(0, 3) == 0) sw = 16'($urandom);
      ready = 1'($urandom_range(0, 1));
      enter = 0;
      repeat ($urandom_range(1, 10)) @(negedge clock);
    end
    ready = 1;
    repeat (20) @(negedge clock);

    // Reset while offering
    ready = 0;
    sw = 16'h3456; press(8, 2);
    reached = 0;
    for (int k = 0; k < 40 && !reached; k++) begin
      if (bus1.guess_valid) reached = 1;
      else @(negedge clock);
    end
    chk("rst_reach_offer", reached, 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", bus1.guess_valid, 0);
    chk("midrst_guess", bus1.guess, 16'h0000);
    chk("midrst_error", err1, 0);
    chk("midrst_pulse", pulse1, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    chk("post_rst_valid", bus1.guess_valid, 0);

    cmp_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
